// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to a
// one-cycle-latency instruction SRAM, and buffers {inst, pc} pairs in a small
// FIFO that decode drains with valid/ready. Redirects flush wrong-path state;
// halt stops new fetches until reset.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic        fetch_idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

  typedef enum logic {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          pop;
  logic          push;
  logic [CW:0]   credit;

  assign id_valid = (count != '0);
  assign id_inst  = inst_mem[rd_ptr];
  assign id_pc    = pc_mem[rd_ptr];
  assign im_addr  = fetch_pc;
  assign pop      = id_valid & id_ready;
  // A response returning in a redirect cycle belongs to the wrong path.
  assign push     = inflight & ~redirect_valid;

  // Occupancy the queue will have once the current pop and the in-flight
  // response settle; a new request is allowed only if it will find a slot.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

  // Next-state logic and decoded outputs of the fetch FSM.
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    im_req     = 1'b0;
    fetch_idle = 1'b0;
    if (state == ST_FETCH && halt_req) begin
      state_next = ST_HALTED;
    end
    if (!rst && state == ST_FETCH && !halt_req && !redirect_valid &&
        credit < DEPTH_V) begin
      im_req = 1'b1;
    end
    if (state == ST_HALTED && count == '0 && !inflight) begin
      fetch_idle = 1'b1;
    end
  end

  // FSM state register; HALTED is left only through reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Fetch PC, request tracking and queue bookkeeping; redirect wins over all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~32'h0000_0003;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= im_req;
      if (im_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        req_pc   <= fetch_pc;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage written on push.
  // NOTE: the storage array is deliberately not reset; entries are only read
  // while count says they are valid, so reset would add cost for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= im_rdata;
      pc_mem[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end of the pipelined RV32 core; sits directly upstream of the decoder.
- Owns the fetch PC and issues word requests to the synchronous instruction SRAM, which returns data exactly one cycle after a request.
- Buffers returned instructions with their PCs in a small FIFO that the decode stage drains through a valid/ready handshake.
- Accepts PC redirects from the branch/jump unit, flushes wrong-path state, and stops fetching on halt.

Parameters:
RESET_PC  32'h0000_0000  fetch PC loaded on reset
DEPTH     2  instruction queue entries (power of two, >=2)

Ports:
clk             input   1   clock, all state on rising edge
rst             input   1   asynchronous, active-high reset
redirect_valid  input   1   taken branch/jump; load redirect_pc
redirect_pc     input   32  redirect target; bits [1:0] ignored (forced 0)
halt_req        input   1   stop issuing new fetches (ecall/halt); sticky
im_req          output  1   fetch request this cycle (SRAM always accepts)
im_addr         output  32  fetch address = fetch_pc
im_rdata        input   32  SRAM read data, valid the cycle after im_req
id_valid        output  1   queue head valid
id_ready        input   1   decode accepts head
id_inst         output  32  head instruction
id_pc           output  32  head PC
fetch_idle      output  1   HALTED, queue empty, nothing in flight

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, queue count/rd/wr pointers=0, inflight=0, state=FETCH. During reset im_req=0, id_valid=0, fetch_idle=0.
- FSM with two states:
  - FETCH -> HALTED when halt_req=1 (sampled at edge).
  - HALTED stays until rst. No redirect exits HALTED.
- Combinational outputs:
  - pop = id_valid & id_ready.
  - im_req = (state==FETCH) & !halt_req & !redirect_valid & (count + inflight - pop < DEPTH).
  - im_addr = fetch_pc.
- On im_req: fetch_pc <= fetch_pc+4 (32-bit wrap 0xFFFF_FFFC -> 0); inflight <= 1; the request PC is held in a req_pc register.
- Cycle after a request (inflight=1): push {im_rdata, req_pc} at wr_ptr unless dropped; inflight clears unless a new request issues.
- Credit rule guarantees no overflow. Push into a full queue is impossible by construction; the bench asserts it.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Throughput: 1 instruction/cycle with id_ready held high, DEPTH>=2.
- Latency: reset release -> im_req in the first cycle; id_valid in the second cycle.
- id_inst/id_pc hold the head entry and stay stable while id_valid=1 and id_ready=0.
- Redirect (redirect_valid=1 at edge, highest priority):
  - Flush the queue: count=0, pointers=0.
  - Drop any in-flight response, including the one returning in that same cycle.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No request issues in the redirect cycle; the first request to the target issues the next cycle.
  - A head popped in the redirect cycle is still presented, but decode treats it as wrong-path.
- Redirect in HALTED: updates fetch_pc and flushes; no fetch issues.
- halt_req with a request in flight: that response is still enqueued and the queue still drains.
- fetch_idle = (state==HALTED) & count==0 & inflight==0.
- Reset mid-operation: all state returns to reset values immediately; any pending SRAM data is ignored.

Test Plan:
1. Reset release, RESET_PC=0, SRAM word i = 0x0000_0013+i, id_ready=1 -> im_addr 0,4,8,... on consecutive cycles; id_valid from cycle 2; id_pc/id_inst = 0/0x13, 4/0x14, ... with one instruction per cycle.
2. id_ready=0 from the start -> exactly 2 requests (0,4); im_req stays low; id_pc=0 held stable. Raise id_ready -> pcs 0,4,8 in order with no duplicates or gaps.
3. Steady stream, redirect_valid=1 with redirect_pc=0x0000_0103 while a response is in flight -> in-flight data discarded, queue empty; next cycle im_addr=0x100; the next id_pc after that is 0x100.
4. Redirect while queue full and id_ready=0 -> count=0 the next cycle; fetch resumes at the target; no stale instruction appears at id.
5. halt_req pulse with one request in flight -> that instruction is delivered; no further im_req; fetch_idle=1 after drain; a later redirect_valid never raises im_req.
6. fetch_pc=0xFFFF_FFFC, then assert rst mid-stream -> first fetch after the wrap is addr 0; on rst, id_valid drops the same cycle; after release im_addr=RESET_PC.
